// File: rtl/mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb : two-requester round-robin arbiter for one memory controller |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arb #(
   parameter int TIMEOUT_CYC = 64,
   parameter int GAP_CYC     = 4
) (
   input  logic        clk,
   input  logic        sys_rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [7:0]  addr0,
   input  logic [15:0] wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [7:0]  addr1,
   input  logic [15:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err,
   output logic [15:0] rdata,
   output logic        owner,
   output logic        mc_sel,
   output logic        mc_we,
   output logic [7:0]  mc_addr,
   output logic [15:0] mc_wdata,
   input  logic        mc_ready,
   input  logic [15:0] mc_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
   localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  gap_q, gap_d;
   logic        owner_q, owner_d;
   logic        mc_sel_q, mc_sel_d;
   logic        mc_we_q, mc_we_d;
   logic [7:0]  mc_addr_q, mc_addr_d;
   logic [15:0] mc_wdata_q, mc_wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        err_q, err_d;
   logic        grant;

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         cnt_q      <= 16'h0000;
         gap_q      <= 8'h00;
         owner_q    <= 1'b1;
         mc_sel_q   <= 1'b0;
         mc_we_q    <= 1'b0;
         mc_addr_q  <= 8'h00;
         mc_wdata_q <= 16'h0000;
         rdata_q    <= 16'h0000;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         owner_q    <= owner_d;
         mc_sel_q   <= mc_sel_d;
         mc_we_q    <= mc_we_d;
         mc_addr_q  <= mc_addr_d;
         mc_wdata_q <= mc_wdata_d;
         rdata_q    <= rdata_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      owner_d    = owner_q;
      mc_sel_d   = mc_sel_q;
      mc_we_d    = mc_we_q;
      mc_addr_d  = mc_addr_q;
      mc_wdata_d = mc_wdata_q;
      rdata_d    = rdata_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      err_d      = 1'b0;
      grant      = 1'b0;

      case (state_q)
         IDLE: begin
            if ((req0 || req1) && mc_ready) begin
               // On a tie the requester that did not win last time goes next
               grant      = (req0 && req1) ? ~owner_q : req1;
               owner_d    = grant;
               mc_we_d    = grant ? we1 : we0;
               mc_addr_d  = grant ? addr1 : addr0;
               mc_wdata_d = grant ? wdata1 : wdata0;
               mc_sel_d   = 1'b1;
               cnt_d      = 16'h0000;
               state_d    = ISSUE;
            end
         end
         ISSUE, BUSY: begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            // Completion is checked first so it wins a same-cycle timeout
            if (state_q == BUSY && mc_ready) begin
               if (!mc_we_q) begin
                  rdata_d = mc_rdata;
               end
               ack0_d   = ~owner_q;
               ack1_d   = owner_q;
               mc_sel_d = 1'b0;
               gap_d    = 8'h00;
               state_d  = GAP;
            end else if (cnt_q == TO_LAST) begin
               ack0_d   = ~owner_q;
               ack1_d   = owner_q;
               err_d    = 1'b1;
               mc_sel_d = 1'b0;
               gap_d    = 8'h00;
               state_d  = GAP;
            end else if (state_q == ISSUE && !mc_ready) begin
               state_d = BUSY;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign owner    = owner_q;
   assign mc_sel   = mc_sel_q;
   assign mc_we    = mc_we_q;
   assign mc_addr  = mc_addr_q;
   assign mc_wdata = mc_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arb : directed bench for mem_arb with a busy-counting ctrl    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [7:0]  addr0 = 8'h00, addr1 = 8'h00;
   logic [15:0] wdata0 = 16'h0000, wdata1 = 16'h0000;
   logic        ack0, ack1, err, owner, mc_sel, mc_we;
   logic [15:0] rdata, mc_wdata;
   logic [7:0]  mc_addr;
   logic        mc_ready = 1'b1;
   logic [15:0] mc_rdata = 16'h0000;

   int n_vec = 0;
   int n_err = 0;

   // controller model state
   int busy_len  = 16;
   int busy_left = 0;
   bit sel_seen  = 1'b0;
   bit hold_busy = 1'b0;

   // protocol monitor state
   int viol      = 0;
   int ack_total = 0;
   int low_run   = 0;
   int min_low   = 999;

   mem_arb #(.TIMEOUT_CYC(64), .GAP_CYC(4)) dut (
      .clk(clk), .sys_rst(sys_rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .owner(owner),
      .mc_sel(mc_sel), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
      .mc_ready(mc_ready), .mc_rdata(mc_rdata)
   );

   always #5 clk = ~clk;

   // Controller goes busy for busy_len cycles after each mc_sel rise
   always @(negedge clk) begin
      if (mc_sel && !sel_seen) busy_left = busy_len;
      sel_seen = mc_sel;
      if (hold_busy) mc_ready = 1'b0;
      else if (busy_left > 0) begin
         mc_ready  = 1'b0;
         busy_left = busy_left - 1;
      end else mc_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (ack0 && ack1) viol = viol + 1;
      if (err && !ack0 && !ack1) viol = viol + 1;
      if (ack0 || ack1) ack_total = ack_total + 1;
      if (mc_sel) begin
         if (low_run > 0 && low_run < min_low) min_low = low_run;
         low_run = 0;
      end else low_run = low_run + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_sel(input int lim, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc = cyc + 1;
      end while (!mc_sel && cyc <= lim);
   endtask

   // Counts negedges from the mc_sel-rise sample until an ack is seen
   task automatic wait_ack(input int lim, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc = cyc + 1;
      end while (!(ack0 || ack1) && cyc <= lim);
   endtask

   initial begin
      int cyc;
      int snap;

      // reset state
      @(negedge clk);
      check("rst_mc_sel", mc_sel, 0);
      check("rst_mc_we", mc_we, 0);
      check("rst_acks_err", {ack0, ack1, err}, 0);
      check("rst_mc_addr", mc_addr, 8'h00);
      check("rst_mc_wdata", mc_wdata, 16'h0000);
      check("rst_rdata", rdata, 16'h0000);
      check("rst_owner", owner, 1);
      @(negedge clk);
      sys_rst = 1'b0;
      repeat (2) @(negedge clk);

      // single write; req dropped and inputs changed right after grant
      busy_len = 16;
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h12; wdata0 = 16'hA5A5;
      wait_sel(50, cyc);
      check("wr_grant", mc_sel, 1);
      req0 = 1'b0; addr0 = 8'hFF; wdata0 = 16'h0000; we0 = 1'b0;
      wait_ack(100, cyc);
      check("wr_latency", cyc, 17);
      check("wr_ack0_ack1_err", {ack0, ack1, err}, 3'b100);
      check("wr_mc_sel_low", mc_sel, 0);
      check("wr_mc_addr", mc_addr, 8'h12);
      check("wr_mc_wdata", mc_wdata, 16'hA5A5);
      check("wr_mc_we", mc_we, 1);
      check("wr_rdata_kept", rdata, 16'h0000);
      check("wr_owner", owner, 0);
      @(negedge clk);
      check("wr_ack_pulse", {ack0, err}, 0);
      repeat (8) @(negedge clk);

      // IDLE with controller busy must not grant, then a read on port 1
      hold_busy = 1'b1;
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h34; mc_rdata = 16'h5A5A;
      repeat (5) @(negedge clk);
      check("idle_busy_nogrant", mc_sel, 0);
      hold_busy = 1'b0;
      wait_sel(50, cyc);
      check("rd_grant", mc_sel, 1);
      req1 = 1'b0;
      wait_ack(100, cyc);
      check("rd_latency", cyc, 17);
      check("rd_ack0_ack1_err", {ack0, ack1, err}, 3'b010);
      check("rd_rdata", rdata, 16'h5A5A);
      check("rd_owner", owner, 1);
      check("rd_mc_addr", mc_addr, 8'h34);
      check("rd_mc_we", mc_we, 0);
      repeat (8) @(negedge clk);

      // timeout: controller never goes busy
      busy_len = 0;
      mc_rdata = 16'h1234;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
      wait_sel(50, cyc);
      check("to_grant", mc_sel, 1);
      req0 = 1'b0;
      wait_ack(200, cyc);
      check("to_latency", cyc, 64);
      check("to_ack0_ack1_err", {ack0, ack1, err}, 3'b101);
      check("to_rdata_kept", rdata, 16'h5A5A);
      check("to_mc_sel_low", mc_sel, 0);
      @(negedge clk);
      check("to_err_clears", {ack0, err}, 0);
      repeat (8) @(negedge clk);

      // tie after reset: both held, expect 0,1,0,1 with 5 low cycles between
      sys_rst = 1'b1;
      @(negedge clk);
      sys_rst = 1'b0;
      busy_len = 3;
      min_low = 999;
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 16'h0101;
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h02; wdata1 = 16'h0202;
      for (int k = 0; k < 4; k++) begin
         wait_ack(100, cyc);
         check($sformatf("tie_order%0d", k), {ack0, ack1}, (k % 2 == 0) ? 2'b10 : 2'b01);
         check($sformatf("tie_addr%0d", k), mc_addr, (k % 2 == 0) ? 8'h01 : 8'h02);
      end
      req0 = 1'b0; req1 = 1'b0;
      // GAP_CYC cycles in GAP plus the IDLE cycle in which the grant is made
      check("tie_gap_low", min_low, 5);
      check("tie_owner", owner, 1);
      repeat (10) @(negedge clk);

      // reset in the middle of BUSY
      busy_len = 16;
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h77; wdata0 = 16'hBEEF;
      wait_sel(50, cyc);
      check("mid_grant", mc_sel, 1);
      repeat (5) @(negedge clk);
      snap = ack_total;
      #2 sys_rst = 1'b1;
      req0 = 1'b0;
      #1;
      check("mid_mc_sel", mc_sel, 0);
      check("mid_owner", owner, 1);
      check("mid_mc_we_addr", {mc_we, mc_addr}, 9'h000);
      check("mid_mc_wdata", mc_wdata, 16'h0000);
      @(negedge clk);
      sys_rst = 1'b0;
      repeat (20) @(negedge clk);
      check("mid_no_ack", ack_total, snap);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h56; wdata0 = 16'h1357;
      wait_sel(50, cyc);
      check("post_grant", mc_sel, 1);
      req0 = 1'b0;
      wait_ack(100, cyc);
      check("post_latency", cyc, 17);
      check("post_ack0_ack1_err", {ack0, ack1, err}, 3'b100);
      check("post_mc_addr", mc_addr, 8'h56);
      repeat (4) @(negedge clk);

      check("ack_exclusive_err_gated", viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
